// File: rtl/mode_sel_ctrl_if.sv
// mode_sel_ctrl_if - signal bundle between the colour-mode controller and
// its surroundings (buttons, VGA sync, colour datapath).
//
// Signals:
//   BTN_UP    raw up pushbutton, asynchronous, active-high, bouncy
//   BTN_DN    raw down pushbutton, asynchronous, active-high, bouncy
//   VS_N      VGA vertical sync, active-low, synchronous to the controller clock
//   MODE      committed colour mode, 0..N_MODES-1
//   MODE_CHG  one-cycle pulse in the cycle MODE takes a new value
//   BUSY      high while steps are still queued
//
// Modports:
//   master  the environment: drives buttons and sync, observes mode/status
//   slave   the controller itself
interface mode_sel_ctrl_if;
  logic       BTN_UP;
  logic       BTN_DN;
  logic       VS_N;
  logic [2:0] MODE;
  logic       MODE_CHG;
  logic       BUSY;

  modport master (
    output BTN_UP, BTN_DN, VS_N,
    input  MODE, MODE_CHG, BUSY
  );

  modport slave (
    input  BTN_UP, BTN_DN, VS_N,
    output MODE, MODE_CHG, BUSY
  );
endinterface

// File: rtl/mode_sel_ctrl.sv
// mode_sel_ctrl - colour-mode counter for the VGA colour datapath.
//
// Each raw pushbutton is synchronised (2 FF) and debounced; a debounced
// 0->1 transition becomes a one-cycle step request. Requests accumulate in a
// small signed queue (PEND, saturating at +/-MAX_PEND) and at most one step is
// committed per video frame, on the falling edge of VS_N, so the colour
// pattern never changes mid-frame.
//
// Ports:
//   C      system clock, rising edge
//   RST_N  synchronous reset, active-low
//   bus    slave side of mode_sel_ctrl_if (BTN_UP, BTN_DN, VS_N in;
//          MODE, MODE_CHG, BUSY out, all registered)
//
// Parameters:
//   N_MODES    number of colour modes, 2..8; MODE wraps both ways
//   DB_CYCLES  stable cycles needed to accept a button level change, 2..65535
//   MAX_PEND   saturation magnitude of the pending-step queue, 1..7
module mode_sel_ctrl #(
  parameter int N_MODES   = 6,
  parameter int DB_CYCLES = 16,
  parameter int MAX_PEND  = 3
) (
  input logic            C,
  input logic            RST_N,
  mode_sel_ctrl_if.slave bus
);

  localparam int                 CNT_W     = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [2:0]         MODE_LAST = 3'(N_MODES - 1);
  localparam logic signed [4:0]  PEND_HI   = 5'(MAX_PEND);
  localparam logic signed [4:0]  PEND_LO   = -PEND_HI;

  // Index 0 is the up button, index 1 the down button.
  logic [1:0]       raw;
  logic [1:0]       sync_a;
  logic [1:0]       sync_b;
  logic [1:0]       stable;
  logic [1:0]       press;
  logic [CNT_W-1:0] db_cnt [2];

  assign raw = {bus.BTN_DN, bus.BTN_UP};

  // ---------------------------------------------------------------------------
  // Synchroniser + debounce. A level change is accepted only after the synced
  // level has differed from the stable level for DB_CYCLES consecutive
  // cycles; any return to the stable level restarts the count.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others (the two
  // synchroniser stages rely on this to stay two distinct flops).
  always_ff @(posedge C) begin
    if (!RST_N) begin
      sync_a <= '0;
      sync_b <= '0;
      stable <= '0;
      press  <= '0;
      // NOTE: the debounce counters are a tiny register array, not a RAM, so
      // clearing them in reset is cheap and discards any half-counted press.
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync_b[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          stable[i] <= sync_b[i];
          db_cnt[i] <= '0;
          // Press event only on the accepted 0->1 transition; release is silent.
          press[i]  <= sync_b[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame detection, step commit and request queue.
  // ---------------------------------------------------------------------------
  logic                vs_prev;
  logic                fs;
  logic                up_ev;
  logic                dn_ev;
  logic                commit;
  logic [2:0]          mode_q;
  logic [2:0]          mode_next;
  logic signed [3:0]   pend;
  logic signed [4:0]   pend_step;
  logic signed [4:0]   pend_req;
  logic signed [4:0]   pend_next;
  logic                chg_q;
  logic                busy_q;

  // NOTE: every variable written here gets a default first, so no path
  // through the block can leave one unassigned and infer a latch.
  always_comb begin
    fs        = vs_prev & ~bus.VS_N;
    up_ev     = press[0];
    dn_ev     = press[1];
    commit    = 1'b0;
    mode_next = mode_q;
    pend_step = {pend[3], pend};

    // Commit first: a request arriving in the fs cycle is queued, not applied.
    if (fs && !pend[3] && (pend != '0)) begin
      commit    = 1'b1;
      mode_next = (mode_q == MODE_LAST) ? 3'd0 : mode_q + 3'd1;
      pend_step = pend_step - 5'sd1;
    end else if (fs && pend[3]) begin
      commit    = 1'b1;
      mode_next = (mode_q == 3'd0) ? MODE_LAST : mode_q - 3'd1;
      pend_step = pend_step + 5'sd1;
    end

    // Simultaneous up and down presses cancel.
    pend_req = pend_step;
    if (up_ev && !dn_ev) begin
      pend_req = pend_step + 5'sd1;
    end else if (dn_ev && !up_ev) begin
      pend_req = pend_step - 5'sd1;
    end

    // Excess presses are dropped by clamping the queue.
    pend_next = pend_req;
    if (pend_req > PEND_HI) begin
      pend_next = PEND_HI;
    end else if (pend_req < PEND_LO) begin
      pend_next = PEND_LO;
    end
  end

  always_ff @(posedge C) begin
    if (!RST_N) begin
      // Idle sync level, so VS_N already low out of reset is not a frame start.
      vs_prev <= 1'b1;
      mode_q  <= '0;
      pend    <= '0;
      chg_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      vs_prev <= bus.VS_N;
      mode_q  <= mode_next;
      pend    <= pend_next[3:0];
      chg_q   <= commit;
      // Registered from the next queue value so BUSY tracks PEND cycle-for-cycle.
      busy_q  <= (pend_next != '0);
    end
  end

  assign bus.MODE     = mode_q;
  assign bus.MODE_CHG = chg_q;
  assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_mode_sel_ctrl.sv
// tb_mode_sel_ctrl - directed, self-checking bench for mode_sel_ctrl
// (N_MODES=6, DB_CYCLES=4, MAX_PEND=3). A table of press/frame records with
// hand-computed results covers wrap, queueing, saturation and cancel; hand
// sequences cover reset, debounce, fs/press collision and reset mid-queue.
module tb_mode_sel_ctrl;

  localparam int N_MODES   = 6;
  localparam int DB_CYCLES = 4;
  localparam int MAX_PEND  = 3;

  logic clk;
  logic rst_n;

  mode_sel_ctrl_if bus ();

  mode_sel_ctrl #(
    .N_MODES  (N_MODES),
    .DB_CYCLES(DB_CYCLES),
    .MAX_PEND (MAX_PEND)
  ) dut (
    .C    (clk),
    .RST_N(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int chg_cnt  = 0;

  typedef struct {
    int ups;
    int dns;
    int frames;
    int exp_mode;
    int exp_busy;
    int exp_chg;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Advance one clock; inputs driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full debounced press and release of the selected button(s).
  task automatic press_btn(input bit up, input bit dn);
    bus.BTN_UP = up;
    bus.BTN_DN = dn;
    repeat (8) tick();
    bus.BTN_UP = 1'b0;
    bus.BTN_DN = 1'b0;
    repeat (8) tick();
  endtask

  // One VS_N low pulse; counts MODE_CHG cycles into chg_cnt. VS_N is held
  // low several cycles, so a repeated commit would show up in the count.
  task automatic frame();
    bus.VS_N = 1'b0;
    repeat (4) begin
      tick();
      if (bus.MODE_CHG) chg_cnt++;
    end
    bus.VS_N = 1'b1;
    repeat (4) begin
      tick();
      if (bus.MODE_CHG) chg_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    int lat;

    // ups, dns, frames, mode, busy, chg  (starting from MODE=1, PEND=0)
    vecs = '{
      '{1, 0, 1, 2, 0, 1},
      '{1, 0, 1, 3, 0, 1},
      '{1, 0, 1, 4, 0, 1},
      '{1, 0, 1, 5, 0, 1},
      '{1, 0, 1, 0, 0, 1},   // wrap up 5 -> 0
      '{0, 1, 1, 5, 0, 1},   // wrap down 0 -> 5
      '{0, 1, 0, 5, 1, 0},   // queued, not yet committed
      '{0, 0, 1, 4, 0, 1},
      '{5, 0, 0, 4, 1, 0},   // saturates at +3
      '{0, 0, 3, 1, 0, 3},   // 4 -> 5 -> 0 -> 1
      '{0, 0, 1, 1, 0, 0},   // queue empty: no change
      '{0, 5, 0, 1, 1, 0},   // saturates at -3
      '{0, 0, 4, 4, 0, 3},   // 1 -> 0 -> 5 -> 4, fourth frame idle
      '{1, 1, 1, 4, 0, 0},   // opposite press cancels
      '{2, 1, 2, 5, 0, 1}    // net +1
    };

    bus.BTN_UP = 1'b0;
    bus.BTN_DN = 1'b0;
    bus.VS_N   = 1'b1;
    rst_n      = 1'b0;

    // Reset / idle
    repeat (3) tick();
    rst_n = 1'b1;
    check("reset_mode", int'(bus.MODE), 0);
    check("reset_chg", int'(bus.MODE_CHG), 0);
    check("reset_busy", int'(bus.BUSY), 0);
    bad = 0;
    repeat (50) begin
      tick();
      if (bus.MODE != 3'd0 || bus.MODE_CHG || bus.BUSY) bad++;
    end
    check("idle_outputs_disturbed", bad, 0);

    // Debounce: toggling every 2 cycles never gets through
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus.BTN_UP = ~bus.BTN_UP;
      repeat (2) begin
        tick();
        if (bus.BUSY) bad++;
      end
    end
    repeat (10) begin
      tick();
      if (bus.BUSY) bad++;
    end
    check("glitch_busy_cycles", bad, 0);

    // Held press: BUSY rises DB_CYCLES+2..+3 cycles after the raw edge
    bus.BTN_UP = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (lat == 0 && bus.BUSY) lat = i;
    end
    check("press_latency_ok", int'(lat >= 6 && lat <= 7), 1);
    check("press_mode_unchanged", int'(bus.MODE), 0);
    bus.BTN_UP = 1'b0;
    repeat (8) tick();
    chg_cnt = 0;
    frame();
    check("first_commit_mode", int'(bus.MODE), 1);
    check("first_commit_chg_cycles", chg_cnt, 1);
    check("first_commit_busy", int'(bus.BUSY), 0);

    // Table-driven vectors
    for (int r = 0; r < $size(vecs); r++) begin
      chg_cnt = 0;
      repeat (vecs[r].ups) press_btn(1'b1, 1'b0);
      repeat (vecs[r].dns) press_btn(1'b0, 1'b1);
      repeat (vecs[r].frames) frame();
      check($sformatf("vec%0d_mode", r), int'(bus.MODE), vecs[r].exp_mode);
      check($sformatf("vec%0d_busy", r), int'(bus.BUSY), vecs[r].exp_busy);
      check($sformatf("vec%0d_chg", r), chg_cnt, vecs[r].exp_chg);
    end

    // Both buttons debounced on the same cycle cancel
    press_btn(1'b1, 1'b1);
    check("both_busy", int'(bus.BUSY), 0);
    chg_cnt = 0;
    frame();
    check("both_mode", int'(bus.MODE), 5);
    check("both_chg", chg_cnt, 0);

    // Up event in the same cycle as fs with empty queue: not committed there
    bus.BTN_UP = 1'b1;
    repeat (6) tick();
    bus.VS_N = 1'b0;
    tick();
    check("coll_mode", int'(bus.MODE), 5);
    check("coll_chg", int'(bus.MODE_CHG), 0);
    check("coll_busy", int'(bus.BUSY), 1);
    repeat (2) tick();
    bus.BTN_UP = 1'b0;
    bus.VS_N   = 1'b1;
    repeat (10) tick();
    check("coll_held_mode", int'(bus.MODE), 5);
    chg_cnt = 0;
    frame();
    check("coll_next_mode", int'(bus.MODE), 0);
    check("coll_next_chg", chg_cnt, 1);
    check("coll_next_busy", int'(bus.BUSY), 0);

    // Reset mid-queue: MODE=4, PEND=+2
    chg_cnt = 0;
    press_btn(1'b0, 1'b1);
    press_btn(1'b0, 1'b1);
    frame();
    frame();
    check("pre_rst_mode", int'(bus.MODE), 4);
    press_btn(1'b1, 1'b0);
    press_btn(1'b1, 1'b0);
    check("pre_rst_busy", int'(bus.BUSY), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_mode", int'(bus.MODE), 0);
    check("rst_mid_busy", int'(bus.BUSY), 0);
    chg_cnt = 0;
    frame();
    frame();
    check("rst_mid_chg", chg_cnt, 0);
    check("rst_mid_mode_after", int'(bus.MODE), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mode_sel_ctrl.md
Name: mode_sel_ctrl

Overview:
- Controls the colour-mode counter used by the VGA colour datapath.
- Debounces the raw up and down pushbuttons and turns each press into a step request.
- Queues the requests and commits at most one step per video frame, at the start of the vertical sync pulse, so the colour mode never changes mid-frame.
- Its MODE output drives the colour-pattern select directly.

Parameters:
N_MODES, 6, number of colour modes; MODE counts 0..N_MODES-1 and wraps both ways; legal range 2..8
DB_CYCLES, 16, consecutive stable cycles needed to accept a button level change; legal range 2..65535
MAX_PEND, 3, saturation magnitude of the pending-step accumulator; legal range 1..7

Ports:
C  input  1  system clock; all logic is on its rising edge
RST_N  input  1  synchronous reset, active-low
BTN_UP  input  1  raw up button, asynchronous, active-high, bouncy
BTN_DN  input  1  raw down button, asynchronous, active-high, bouncy
VS_N  input  1  VGA vertical sync, active-low, synchronous to C
MODE  output  3  committed colour mode, 0..N_MODES-1
MODE_CHG  output  1  one-cycle pulse in the cycle MODE changes
BUSY  output  1  high while PEND != 0

Behaviour:
- Reset: RST_N low at a rising edge of C clears all state:
  - MODE=0, MODE_CHG=0, BUSY=0, PEND=0;
  - both synchronisers and debounce counters cleared, stable levels=0;
  - vs_prev=1.
- Reset mid-operation discards any pending steps and any in-progress debounce count.
- Synchroniser: each button passes through a 2-FF synchroniser before any other logic.
- Debounce, per button:
  - counter width is clog2(DB_CYCLES);
  - if the synced level equals the stable level, the counter is cleared;
  - otherwise the counter increments, and when it reaches DB_CYCLES-1 the stable level takes the synced level and the counter clears;
  - a single-cycle glitch shorter than DB_CYCLES never changes the stable level.
- Press event:
  - a one-cycle pulse (up_ev or dn_ev) on a stable-level 0->1 transition;
  - release generates nothing;
  - raw rise to event is DB_CYCLES+2 or DB_CYCLES+3 cycles.
- Frame event: fs = vs_prev & ~VS_N, i.e. a VS_N falling edge; vs_prev registers VS_N every cycle.
- PEND is a signed 4-bit accumulator in [-MAX_PEND, +MAX_PEND]. Next-state order within one cycle:
  1. Commit step:
     - if fs and PEND>0: MODE = (MODE==N_MODES-1) ? 0 : MODE+1, and PEND-1;
     - if fs and PEND<0: MODE = (MODE==0) ? N_MODES-1 : MODE-1, and PEND+1;
     - if fs and PEND==0: nothing happens.
  2. Request:
     - up_ev & ~dn_ev adds +1;
     - dn_ev & ~up_ev adds -1;
     - up_ev & dn_ev together cancel (net 0).
  3. Saturation: the result of steps 1 and 2 clamps to ±MAX_PEND; excess presses are dropped silently.
- Consequences of this order:
  - a press in the same cycle as fs is not applied at that fs;
  - an opposite press cancels one queued step.
- MODE_CHG=1 in the cycle after a commit edge, aligned with the new MODE value; otherwise 0.
- MODE updates only on fs. MODE is registered; no combinational path from any input to any output.
- BUSY is registered from the next PEND value, so BUSY and PEND stay in the same cycle.
- VS_N held low does not generate repeated fs.
- VS_N already low out of reset does not produce fs until it goes high and falls again.

Test Plan:
1. Reset/idle, DB_CYCLES=4, N_MODES=6: RST_N low 3 cycles, then high for 50 cycles with no stimulus -> MODE=0, MODE_CHG=0, BUSY=0 throughout.
2. Debounce:
   - BTN_UP toggles every 2 cycles for 20 cycles, then stays low -> no up_ev, BUSY stays 0.
   - BTN_UP then held high 10 cycles -> BUSY rises 6 or 7 cycles after the rising edge.
   - The next VS_N fall -> MODE 0->1, with MODE_CHG pulsed for exactly 1 cycle.
3. Wrap, N_MODES=6:
   - Six up presses, each committed by its own frame -> MODE sequence 1,2,3,4,5,0.
   - One down press then a frame -> MODE 0->5.
4. Queue and saturation, MAX_PEND=3:
   - Five up presses within one frame -> BUSY=1.
   - Next three VS_N falls give MODE 0->1->2->3; BUSY=0 after the third; the fourth VS_N fall gives no change and no MODE_CHG.
5. Cancel and simultaneous:
   - Up press then down press in the same frame -> PEND=0, BUSY=0, no change at the next fs.
   - Both buttons debounced on the same cycle -> no change.
   - Up event in the same cycle as fs, with PEND=0 -> no commit at that fs; MODE+1 at the following fs.
6. Reset mid-queue: PEND=+2, MODE=4, RST_N pulsed low for 1 cycle -> MODE=0, BUSY=0, and the next two fs produce no MODE_CHG.
